// File: rtl/plru_replacer.sv
// Per-set 3-bit tree-PLRU state for a 4-way cache: records hits and picks/claims victims.
// Optional build macro PLRU_INVALID_FIRST_EN: allocate prefers the lowest invalid way.
module plru_replacer #(
    parameter int NUM_SETS = 16,
    parameter int SET_W    = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_alloc,
    input  logic [SET_W-1:0] req_set,
    input  logic [1:0]       req_way,
    input  logic [3:0]       way_valid,
    output logic             rsp_valid,
    output logic [1:0]       rsp_way,
    output logic             busy
);

    typedef enum logic {ST_IDLE, ST_SWEEP} state_e;

    state_e           state_q, state_d;
    logic [SET_W-1:0] sweep_idx_q, sweep_idx_d;
    logic [2:0]       plru_q [NUM_SETS];
    logic [2:0]       plru_d [NUM_SETS];

    logic             s2_valid_q, s2_valid_d;
    logic             s2_alloc_q, s2_alloc_d;
    logic [SET_W-1:0] s2_set_q, s2_set_d;
    logic [1:0]       s2_way_q, s2_way_d;
    logic [2:0]       s2_bits_q, s2_bits_d;
    logic [3:0]       s2_wvalid_q, s2_wvalid_d;
    logic [1:0]       rsp_way_q, rsp_way_d;

    logic             accept;
    logic [1:0]       plru_victim, victim, touch_way;
    logic [2:0]       new_bits;

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        req_ready   = 1'b0;
        busy        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // flush takes priority, so ready drops in the same cycle
                req_ready = ~flush;
                if (flush) begin
                    state_d     = ST_SWEEP;
                    sweep_idx_d = '0;
                end
            end
            ST_SWEEP: begin
                busy = 1'b1;
                if (flush) begin
                    sweep_idx_d = '0;
                end else if (sweep_idx_q == SET_W'(NUM_SETS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    sweep_idx_d = sweep_idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = req_valid & req_ready;

    always_comb begin
        plru_victim = s2_bits_q[0] ? {1'b1, s2_bits_q[2]} : {1'b0, s2_bits_q[1]};
        victim      = plru_victim;
`ifdef PLRU_INVALID_FIRST_EN
        if (!s2_wvalid_q[0])      victim = 2'd0;
        else if (!s2_wvalid_q[1]) victim = 2'd1;
        else if (!s2_wvalid_q[2]) victim = 2'd2;
        else if (!s2_wvalid_q[3]) victim = 2'd3;
`endif
        touch_way   = s2_alloc_q ? victim : s2_way_q;
        new_bits    = s2_bits_q;
        new_bits[0] = ~touch_way[1];
        if (touch_way[1]) new_bits[2] = ~touch_way[0];
        else              new_bits[1] = ~touch_way[0];
    end

`ifndef PLRU_INVALID_FIRST_EN
    logic unused_wvalid;
    assign unused_wvalid = ^s2_wvalid_q;
`endif

    always_comb begin
        s2_valid_d  = accept;
        s2_alloc_d  = req_alloc;
        s2_set_d    = req_set;
        s2_way_d    = req_way;
        s2_wvalid_d = way_valid;
        // forward the in-flight write so same-set back-to-back requests see fresh bits
        s2_bits_d   = (s2_valid_q && s2_set_q == req_set) ? new_bits : plru_q[req_set];

        plru_d = plru_q;
        if (s2_valid_q) plru_d[s2_set_q] = new_bits;
        if (busy)       plru_d[sweep_idx_q] = 3'b000;

        rsp_valid = s2_valid_q & s2_alloc_q;
        rsp_way_d = rsp_valid ? victim : rsp_way_q;
        rsp_way   = rsp_way_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sweep_idx_q <= '0;
            s2_valid_q  <= 1'b0;
            s2_alloc_q  <= 1'b0;
            s2_set_q    <= '0;
            s2_way_q    <= '0;
            s2_bits_q   <= '0;
            s2_wvalid_q <= '0;
            rsp_way_q   <= '0;
            for (int i = 0; i < NUM_SETS; i++) plru_q[i] <= 3'b000;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            s2_valid_q  <= s2_valid_d;
            s2_alloc_q  <= s2_alloc_d;
            s2_set_q    <= s2_set_d;
            s2_way_q    <= s2_way_d;
            s2_bits_q   <= s2_bits_d;
            s2_wvalid_q <= s2_wvalid_d;
            rsp_way_q   <= rsp_way_d;
            for (int i = 0; i < NUM_SETS; i++) plru_q[i] <= plru_d[i];
        end
    end

endmodule

// File: tb/tb_plru_replacer.sv
// Directed bench for plru_replacer; expected victims are hand-derived from the PLRU tree.
module tb_plru_replacer;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       req_valid;
    logic       req_ready;
    logic       req_alloc;
    logic [3:0] req_set;
    logic [1:0] req_way;
    logic [3:0] way_valid;
    logic       rsp_valid;
    logic [1:0] rsp_way;
    logic       busy;

    int checks = 0;
    int errors = 0;

    plru_replacer #(.NUM_SETS(16), .SET_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_alloc (req_alloc),
        .req_set   (req_set),
        .req_way   (req_way),
        .way_valid (way_valid),
        .rsp_valid (rsp_valid),
        .rsp_way   (rsp_way),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // drive one request across an edge; outputs afterwards belong to that request's stage 2
    task automatic req(input logic alloc, input logic [3:0] set, input logic [1:0] way,
                       input logic [3:0] wv);
        req_valid = 1'b1;
        req_alloc = alloc;
        req_set   = set;
        req_way   = way;
        way_valid = wv;
        cyc();
    endtask

    task automatic idle_in();
        req_valid = 1'b0;
        req_alloc = 1'b0;
        way_valid = 4'hf;
    endtask

    task automatic alloc_chk(input string tag, input logic [3:0] set, input logic [1:0] exp);
        req(1'b1, set, 2'd0, 4'hf);
        chk({tag, "_v"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_way"}, 32'(rsp_way), 32'(exp));
    endtask

    initial begin
        logic [1:0] seq [5];
        logic [1:0] exp_inv;
        seq[0] = 2'd0; seq[1] = 2'd2; seq[2] = 2'd1; seq[3] = 2'd3; seq[4] = 2'd0;
        rst = 1'b1; flush = 1'b0; req_set = '0; req_way = '0;
        idle_in();
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rspv", 32'(rsp_valid), 32'd0);
        chk("rst_rspway", 32'(rsp_way), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // back-to-back allocates on set 3 walk the tree 0,2,1,3,0
        for (int i = 0; i < 5; i++) alloc_chk($sformatf("b2b%0d", i), 4'd3, seq[i]);
        idle_in();
        cyc();
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("rsp_hold", 32'(rsp_way), 32'd0);

        // touch then immediate allocate on the same set
        req(1'b0, 4'd1, 2'd2, 4'hf);
        chk("touch_norsp", 32'(rsp_valid), 32'd0);
        alloc_chk("byp_a", 4'd1, 2'd0);
        alloc_chk("byp_b", 4'd1, 2'd3);
        req(1'b0, 4'd2, 2'd0, 4'hf);
        alloc_chk("byp_c", 4'd2, 2'd2);
        chk("hold_a", 32'(rsp_way), 32'd2);
        req(1'b0, 4'd4, 2'd1, 4'hf);
        chk("hold_touch", 32'(rsp_way), 32'd2);
        idle_in();
        cyc();

        // independent sets
        req(1'b0, 4'd5, 2'd0, 4'hf);
        req(1'b0, 4'd6, 2'd3, 4'hf);
        alloc_chk("set5", 4'd5, 2'd2);
        alloc_chk("set6", 4'd6, 2'd0);

        // dirty every set, then flush
        for (int s = 0; s < 16; s++) req(1'b0, 4'(s), 2'd0, 4'hf);
        idle_in();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("sw_busy%0d", i), 32'(busy), 32'd1);
            chk($sformatf("sw_rdy%0d", i), 32'(req_ready), 32'd0);
            cyc();
        end
        chk("sw_done", 32'(busy), 32'd0);
        chk("sw_rdy", 32'(req_ready), 32'd1);
        alloc_chk("post_f9", 4'd9, 2'd0);
        alloc_chk("post_f0", 4'd0, 2'd0);
        alloc_chk("post_f0b", 4'd0, 2'd2);
        idle_in();
        cyc();
        while (busy) cyc();

        // flush beats a same-cycle request
        req_valid = 1'b1; req_alloc = 1'b1; req_set = 4'd2; flush = 1'b1;
        #1;
        chk("fl_rdy", 32'(req_ready), 32'd0);
        cyc();
        flush = 1'b0;
        idle_in();
        chk("fl_norsp", 32'(rsp_valid), 32'd0);
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_sw_busy", 32'(busy), 32'd0);
        chk("rst_sw_rdy", 32'(req_ready), 32'd1);

        // reset with an allocate in flight drops the response
        alloc_chk("pre_rst0", 4'd11, 2'd0);
        req(1'b1, 4'd11, 2'd0, 4'hf);
        chk("pre_rst1", 32'(rsp_way), 32'd2);
        req(1'b1, 4'd11, 2'd0, 4'hf);
        idle_in();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_p_v", 32'(rsp_valid), 32'd0);
        chk("rst_p_way", 32'(rsp_way), 32'd0);
        alloc_chk("rst_p_set", 4'd11, 2'd0);

        // invalid-way preference on a fresh set
`ifdef PLRU_INVALID_FIRST_EN
        exp_inv = 2'd2;
`else
        exp_inv = 2'd0;
`endif
        req(1'b1, 4'd7, 2'd0, 4'b1011);
        chk("inv_v", 32'(rsp_valid), 32'd1);
        chk("inv_way", 32'(rsp_way), 32'(exp_inv));
        idle_in();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
